// File: rtl/axi_reg_responder_pkg.sv
// Shared types and helpers for the AXI register responder.
//   state_t      : responder FSM states
//   AXI_RESP_*   : B/R response encodings used by this block
//   AXI_BURST_*  : AXI burst type encodings
//   merge_bytes  : byte-enable merge of new write data into a register
//   txn_err      : transaction-wide error (unsupported burst type or beat size)
package axi_reg_responder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WDATA = 2'd1,
        WRESP = 2'd2,
        RDATA = 2'd3
    } state_t;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    // Only full 32-bit beats are served.
    localparam logic [2:0] AXI_SIZE_4B = 3'd2;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++)
            res[8*b +: 8] = strb[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
        return res;
    endfunction

    // WRAP and the reserved burst type, or any beat size other than 4 bytes,
    // turn every beat of the transaction into an error beat.
    function automatic logic txn_err(input logic [1:0] burst, input logic [2:0] size);
        return !(burst == AXI_BURST_FIXED || burst == AXI_BURST_INCR) || (size != AXI_SIZE_4B);
    endfunction

endpackage

// File: rtl/AXI_BUS.sv
// AXI4 bus bundle between the interconnect and its endpoints.
//   Master modport : drives AW/W/AR requests and B/R ready
//   Slave  modport : drives AW/W/AR ready and the B/R responses
interface AXI_BUS #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned AXI_ID_WIDTH   = 4,
    parameter int unsigned AXI_USER_WIDTH = 1
);
    localparam int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

    logic [AXI_ID_WIDTH-1:0]   aw_id;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr;
    logic [7:0]                aw_len;
    logic [2:0]                aw_size;
    logic [1:0]                aw_burst;
    logic [AXI_USER_WIDTH-1:0] aw_user;
    logic                      aw_valid;
    logic                      aw_ready;

    logic [AXI_DATA_WIDTH-1:0] w_data;
    logic [AXI_STRB_WIDTH-1:0] w_strb;
    logic                      w_last;
    logic [AXI_USER_WIDTH-1:0] w_user;
    logic                      w_valid;
    logic                      w_ready;

    logic [AXI_ID_WIDTH-1:0]   b_id;
    logic [1:0]                b_resp;
    logic [AXI_USER_WIDTH-1:0] b_user;
    logic                      b_valid;
    logic                      b_ready;

    logic [AXI_ID_WIDTH-1:0]   ar_id;
    logic [AXI_ADDR_WIDTH-1:0] ar_addr;
    logic [7:0]                ar_len;
    logic [2:0]                ar_size;
    logic [1:0]                ar_burst;
    logic [AXI_USER_WIDTH-1:0] ar_user;
    logic                      ar_valid;
    logic                      ar_ready;

    logic [AXI_ID_WIDTH-1:0]   r_id;
    logic [AXI_DATA_WIDTH-1:0] r_data;
    logic [1:0]                r_resp;
    logic                      r_last;
    logic [AXI_USER_WIDTH-1:0] r_user;
    logic                      r_valid;
    logic                      r_ready;

    modport Master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_user, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_user, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );

    modport Slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_user, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_user, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );

endinterface

// File: rtl/axi_reg_responder_arb.sv
// Two-requester round-robin arbiter between the write (AW) and read (AR)
// address channels.
//   clk, rst  : clock, asynchronous active-high reset
//   en        : arbitration allowed (responder idle)
//   req_wr/rd : AW / AR valid
//   gnt_wr/rd : combinational grant, used directly as AW / AR ready
// The last_wr flop only moves on contention, so a lone request never
// disturbs the fairness order. After reset the write side is favoured.
module axi_reg_responder_arb (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req_wr,
    input  logic req_rd,
    output logic gnt_wr,
    output logic gnt_rd
);

    logic last_wr;
    logic contend;

    assign contend = en && req_wr && req_rd;

    always_comb begin
        gnt_wr = 1'b0;
        gnt_rd = 1'b0;
        if (en) begin
            if (req_wr && req_rd) begin
                gnt_wr = !last_wr;
                gnt_rd = last_wr;
            end else begin
                gnt_wr = req_wr;
                gnt_rd = req_rd;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_wr <= 1'b0;
        else if (contend)
            last_wr <= gnt_wr;
    end

endmodule

// File: rtl/axi_reg_responder.sv
// AXI4 responder terminating one interconnect slave port with a bank of
// 32-bit registers that are also driven out in parallel.
//   clk, rst  : clock, asynchronous active-high reset
//   slave     : AXI4 slave port (AW/W/B/AR/R), one transaction at a time
//   regs_o    : register k on bits [32k+31:32k]
//   reg_wr_o  : one-cycle pulse per register, the cycle after it is written
// The port sees addresses relative to its own window: the word offset is
// addr[AXI_ADDR_WIDTH-1:2], and any offset >= NUM_REGS is an error beat.
module axi_reg_responder
    import axi_reg_responder_pkg::*;
#(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned AXI_ID_WIDTH   = 4,
    parameter int unsigned AXI_USER_WIDTH = 1,
    parameter int unsigned NUM_REGS       = 8,
    parameter logic [31:0] RESET_VAL      = 32'h0
) (
    input  logic                   clk,
    input  logic                   rst,
    AXI_BUS.Slave                  slave,
    output logic [NUM_REGS*32-1:0] regs_o,
    output logic [NUM_REGS-1:0]    reg_wr_o
);

    localparam int unsigned IDX_W = $clog2(NUM_REGS);
    localparam int unsigned WA_W  = AXI_ADDR_WIDTH - 2;

    state_t state_q, state_d;

    logic [NUM_REGS-1:0][31:0] regs_q;

    // Latched transaction context. widx_q always points at the current beat.
    logic [AXI_ID_WIDTH-1:0] id_q;
    logic [WA_W-1:0]         widx_q;
    logic [7:0]              len_q;
    logic [1:0]              burst_q;
    logic                    terr_q;
    logic [7:0]              cnt_q;
    logic                    err_q;
    logic                    over_q;

    logic                      r_valid_q;
    logic [AXI_DATA_WIDTH-1:0] r_data_q;
    logic [1:0]                r_resp_q;
    logic                      r_last_q;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic gnt_wr, gnt_rd;
    logic beat_err, wr_en;
    logic [WA_W-1:0]  widx_nxt;
    logic [IDX_W-1:0] wr_idx;

    logic [WA_W-1:0] rd_widx;
    logic            rd_terr;
    logic            rd_bad;
    logic [31:0]     rd_data;

    logic unused_bits;
    assign unused_bits = ^{slave.aw_user, slave.ar_user, slave.w_user,
                           slave.aw_addr[1:0], slave.ar_addr[1:0]};

    axi_reg_responder_arb u_arb (
        .clk    (clk),
        .rst    (rst),
        .en     (state_q == IDLE),
        .req_wr (slave.aw_valid),
        .req_rd (slave.ar_valid),
        .gnt_wr (gnt_wr),
        .gnt_rd (gnt_rd)
    );

    assign slave.aw_ready = gnt_wr;
    assign slave.ar_ready = gnt_rd;

    assign aw_hs = slave.aw_valid && slave.aw_ready;
    assign w_hs  = slave.w_valid  && slave.w_ready;
    assign b_hs  = slave.b_valid  && slave.b_ready;
    assign ar_hs = slave.ar_valid && slave.ar_ready;
    assign r_hs  = slave.r_valid  && slave.r_ready;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        slave.w_ready = 1'b0;
        slave.b_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (aw_hs)      state_d = WDATA;
                else if (ar_hs) state_d = RDATA;
            end
            WDATA: begin
                slave.w_ready = 1'b1;
                if (w_hs && slave.w_last) state_d = WRESP;
            end
            WRESP: begin
                slave.b_valid = 1'b1;
                if (b_hs) state_d = IDLE;
            end
            RDATA: begin
                if (r_hs && r_last_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- beat addressing ----------------
    // INCR steps the full word offset (wrapping at the address width); the
    // register index is never folded back, so overrun beats become errors.
    assign widx_nxt = (burst_q == AXI_BURST_INCR) ? widx_q + 1'b1 : widx_q;
    assign beat_err = terr_q || (|widx_q[WA_W-1:IDX_W]);
    assign wr_idx   = widx_q[IDX_W-1:0];
    // Beats beyond len+1 (over_q) are swallowed without touching registers.
    assign wr_en    = w_hs && !beat_err && !over_q;

    // Read data source: the first beat comes straight off the AR channel,
    // later beats from the advanced index.
    always_comb begin
        rd_widx = widx_nxt;
        rd_terr = terr_q;
        if (state_q == IDLE) begin
            rd_widx = slave.ar_addr[AXI_ADDR_WIDTH-1:2];
            rd_terr = txn_err(slave.ar_burst, slave.ar_size);
        end
    end

    assign rd_bad  = rd_terr || (|rd_widx[WA_W-1:IDX_W]);
    assign rd_data = rd_bad ? 32'h0 : regs_q[rd_widx[IDX_W-1:0]];

    // ---------------- transaction context and R channel ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_q      <= '0;
            widx_q    <= '0;
            len_q     <= '0;
            burst_q   <= AXI_BURST_FIXED;
            terr_q    <= 1'b0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            over_q    <= 1'b0;
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
            r_resp_q  <= AXI_RESP_OKAY;
            r_last_q  <= 1'b0;
        end else begin
            if (aw_hs) begin
                id_q    <= slave.aw_id;
                widx_q  <= slave.aw_addr[AXI_ADDR_WIDTH-1:2];
                len_q   <= slave.aw_len;
                burst_q <= slave.aw_burst;
                terr_q  <= txn_err(slave.aw_burst, slave.aw_size);
                cnt_q   <= '0;
                err_q   <= 1'b0;
                over_q  <= 1'b0;
            end

            if (ar_hs) begin
                id_q      <= slave.ar_id;
                widx_q    <= rd_widx;
                len_q     <= slave.ar_len;
                burst_q   <= slave.ar_burst;
                terr_q    <= rd_terr;
                cnt_q     <= '0;
                r_valid_q <= 1'b1;
                r_data_q  <= rd_data;
                r_resp_q  <= rd_bad ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                r_last_q  <= (slave.ar_len == 8'd0);
            end

            if (w_hs) begin
                widx_q <= widx_nxt;
                if (beat_err || over_q)
                    err_q <= 1'b1;
                // Last promised beat without w_last: swallow the rest.
                if (!slave.w_last && cnt_q == len_q && !over_q) begin
                    over_q <= 1'b1;
                    err_q  <= 1'b1;
                end else if (!over_q) begin
                    cnt_q <= cnt_q + 8'd1;
                end
                // w_last ahead of the promised beat count.
                if (slave.w_last && !over_q && cnt_q != len_q)
                    err_q <= 1'b1;
            end

            if (r_hs) begin
                if (r_last_q) begin
                    r_valid_q <= 1'b0;
                    r_last_q  <= 1'b0;
                end else begin
                    widx_q   <= widx_nxt;
                    cnt_q    <= cnt_q + 8'd1;
                    r_data_q <= rd_data;
                    r_resp_q <= rd_bad ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                    r_last_q <= (cnt_q + 8'd1 == len_q);
                end
            end
        end
    end

    assign slave.b_id   = id_q;
    assign slave.b_resp = (state_q == WRESP && err_q) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
    assign slave.b_user = '0;

    assign slave.r_valid = r_valid_q;
    assign slave.r_data  = r_data_q;
    assign slave.r_resp  = r_resp_q;
    assign slave.r_last  = r_last_q;
    assign slave.r_id    = id_q;
    assign slave.r_user  = '0;

    // ---------------- register bank ----------------
    for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg
        logic hit;
        assign hit = wr_en && (wr_idx == IDX_W'(k));

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                regs_q[k]   <= RESET_VAL;
                reg_wr_o[k] <= 1'b0;
            end else begin
                reg_wr_o[k] <= hit;
                if (hit)
                    regs_q[k] <= merge_bytes(regs_q[k], slave.w_data, slave.w_strb);
            end
        end
    end

    assign regs_o = regs_q;

endmodule

// File: tb/tb_axi_reg_responder.sv
module tb_axi_reg_responder;

    localparam int          NR = 8;
    localparam logic [31:0] RV = 32'h0;
    localparam int          CW = 512;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    AXI_BUS #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .AXI_ID_WIDTH(4), .AXI_USER_WIDTH(1)) bus ();

    logic [NR*32-1:0] regs_o;
    logic [NR-1:0]    reg_wr_o;

    axi_reg_responder #(
        .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .AXI_ID_WIDTH(4),
        .AXI_USER_WIDTH(1), .NUM_REGS(NR), .RESET_VAL(RV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .slave    (bus),
        .regs_o   (regs_o),
        .reg_wr_o (reg_wr_o)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: register contents and expected write-pulse counts.
    logic [31:0] mdl [NR];
    int          exp_pulses [NR];
    int          got_pulses [NR];
    logic [31:0] wd [$];
    logic [3:0]  ws [$];
    logic [1:0]  rdy_snap;
    logic        b_snap;

    always @(negedge clk)
        for (int k = 0; k < NR; k++)
            if (reg_wr_o[k]) got_pulses[k]++;

    task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NR*32-1:0] mdl_vec();
        logic [NR*32-1:0] v;
        for (int k = 0; k < NR; k++) v[32*k +: 32] = mdl[k];
        return v;
    endfunction

    // Word offset of beat i: base word plus i for INCR, modulo 2^30.
    function automatic logic [29:0] beat_off(input logic [31:0] addr, input logic [1:0] burst, input int i);
        logic [29:0] base;
        base = addr[31:2];
        return (burst == 2'b01) ? base + 30'(i) : base;
    endfunction

    function automatic bit beat_bad(input logic [31:0] addr, input logic [1:0] burst,
                                    input logic [2:0] size, input int i);
        if (!(burst == 2'b00 || burst == 2'b01) || size != 3'd2) return 1'b1;
        return beat_off(addr, burst, i) >= 30'(NR);
    endfunction

    // Apply a write burst to the model, return the expected B response.
    function automatic logic [1:0] mdl_write(input logic [31:0] addr, input logic [7:0] len,
                                             input logic [1:0] burst, input logic [2:0] size,
                                             input int nbeats);
        bit err;
        int off;
        err = (nbeats != int'(len) + 1);
        for (int i = 0; i < nbeats; i++) begin
            if (i > int'(len) || beat_bad(addr, burst, size, i)) begin
                err = 1'b1;
            end else begin
                off = int'(beat_off(addr, burst, i));
                for (int b = 0; b < 4; b++)
                    if (ws[i][b]) mdl[off][8*b +: 8] = wd[i][8*b +: 8];
                exp_pulses[off]++;
            end
        end
        return err ? 2'b10 : 2'b00;
    endfunction

    // Wait for a ready on channel ch (0 AW, 1 AR, 2 W); leaves at posedge+1.
    task automatic hs_wait(input int ch);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            if ((ch == 0 && bus.aw_ready) || (ch == 1 && bus.ar_ready) || (ch == 2 && bus.w_ready)) begin
                ok = 1'b1;
                rdy_snap = {bus.aw_ready, bus.ar_ready};
                b_snap = bus.b_valid;
            end
            @(posedge clk); #1;
        end
        chk($sformatf("handshake_ch%0d", ch), CW'(ok), CW'(1));
    endtask

    task automatic aw_start(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [2:0] size);
        bus.aw_id = id; bus.aw_addr = addr; bus.aw_len = len;
        bus.aw_burst = burst; bus.aw_size = size; bus.aw_valid = 1'b1;
    endtask

    task automatic ar_start(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [2:0] size);
        bus.ar_id = id; bus.ar_addr = addr; bus.ar_len = len;
        bus.ar_burst = burst; bus.ar_size = size; bus.ar_valid = 1'b1;
    endtask

    // W and B phases after AW has been accepted, then compare against model.
    task automatic wr_finish(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input logic [2:0] size, input int nbeats);
        logic [1:0] er;
        bit got;
        for (int i = 0; i < nbeats; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.w_valid = 1'b0;
                @(posedge clk); #1;
            end
            bus.w_data = wd[i]; bus.w_strb = ws[i];
            bus.w_last = (i == nbeats - 1); bus.w_valid = 1'b1;
            hs_wait(2);
        end
        bus.w_valid = 1'b0; bus.w_last = 1'b0;
        chk("b_not_with_wlast", CW'(b_snap), CW'(0));
        er = mdl_write(addr, len, burst, size, nbeats);
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        bus.b_ready = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            if (bus.b_valid) begin
                got = 1'b1;
                chk("b_resp_id", CW'({bus.b_id, bus.b_resp}), CW'({id, er}));
            end
            @(posedge clk); #1;
        end
        bus.b_ready = 1'b0;
        chk("b_seen", CW'(got), CW'(1));
        chk("regs", CW'(regs_o), CW'(mdl_vec()));
        for (int k = 0; k < NR; k++)
            chk($sformatf("pulses_r%0d", k), CW'(got_pulses[k]), CW'(exp_pulses[k]));
        wd.delete(); ws.delete();
    endtask

    task automatic wr_txn(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [2:0] size, input int nbeats);
        aw_start(id, addr, len, burst, size);
        hs_wait(0);
        bus.aw_valid = 1'b0;
        wr_finish(id, addr, len, burst, size, nbeats);
    endtask

    // R phase after AR has been accepted; every beat compared to the model.
    task automatic r_phase(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [2:0] size,
                           input bit rand_rr, input bit chk_lat);
        int beat;
        bit bad;
        logic [31:0] ed;
        beat = 0;
        for (int n = 0; n < 300 && beat <= int'(len); n++) begin
            bus.r_ready = rand_rr ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (chk_lat && n == 0) chk("r_valid_latency", CW'(bus.r_valid), CW'(1));
            if (bus.r_valid && bus.r_ready) begin
                bad = beat_bad(addr, burst, size, beat);
                ed  = bad ? 32'h0 : mdl[int'(beat_off(addr, burst, beat))];
                chk($sformatf("r_beat%0d", beat),
                    CW'({bus.r_id, bus.r_last, bus.r_resp, bus.r_data}),
                    CW'({id, (beat == int'(len)), (bad ? 2'b10 : 2'b00), ed}));
                beat++;
            end
            @(posedge clk); #1;
        end
        bus.r_ready = 1'b0;
        chk("r_beat_count", CW'(beat), CW'(int'(len) + 1));
    endtask

    task automatic rd_txn(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [2:0] size, input bit rand_rr);
        ar_start(id, addr, len, burst, size);
        hs_wait(1);
        bus.ar_valid = 1'b0;
        r_phase(id, addr, len, burst, size, rand_rr, !rand_rr);
    endtask

    initial begin
        logic [31:0] a;
        logic [7:0]  l;
        logic [1:0]  bu;
        logic [2:0]  sz;
        int          nb;

        for (int k = 0; k < NR; k++) begin
            mdl[k] = RV; exp_pulses[k] = 0; got_pulses[k] = 0;
        end
        bus.aw_valid = 0; bus.aw_id = 0; bus.aw_addr = 0; bus.aw_len = 0;
        bus.aw_size = 0; bus.aw_burst = 0; bus.aw_user = 0;
        bus.w_valid = 0; bus.w_data = 0; bus.w_strb = 0; bus.w_last = 0; bus.w_user = 0;
        bus.b_ready = 0;
        bus.ar_valid = 0; bus.ar_id = 0; bus.ar_addr = 0; bus.ar_len = 0;
        bus.ar_size = 0; bus.ar_burst = 0; bus.ar_user = 0;
        bus.r_ready = 0;
        rst = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_outputs",
            CW'({regs_o, reg_wr_o, bus.aw_ready, bus.ar_ready, bus.w_ready, bus.b_valid,
                 bus.r_valid, bus.b_resp, bus.r_resp, bus.r_data, bus.r_last}),
            CW'({{NR{RV}}, {NR{1'b0}}, 5'b0, 2'b00, 2'b00, 32'h0, 1'b0}));
        rst = 1'b0;
        @(posedge clk); #1;

        // Simultaneous AW/AR straight after reset: write first, then read.
        wd = '{32'h0BAD_F00D}; ws = '{4'hF};
        aw_start(4'h1, 32'h0, 8'd0, 2'b01, 3'd2);
        ar_start(4'h2, 32'h0, 8'd0, 2'b01, 3'd2);
        hs_wait(0);
        chk("arb_first_grant_wr", CW'(rdy_snap), CW'(2'b10));
        bus.aw_valid = 1'b0;
        wr_finish(4'h1, 32'h0, 8'd0, 2'b01, 3'd2, 1);
        hs_wait(1);
        bus.ar_valid = 1'b0;
        r_phase(4'h2, 32'h0, 8'd0, 2'b01, 3'd2, 1'b0, 1'b1);

        // Single write of DEADBEEF to offset 0x4.
        wd = '{32'hDEAD_BEEF}; ws = '{4'hF};
        wr_txn(4'h5, 32'h4, 8'd0, 2'b01, 3'd2, 1);
        chk("reg1_deadbeef", CW'(regs_o[63:32]), CW'(32'hDEAD_BEEF));

        // Byte-enabled merge into reg 2.
        wd = '{32'hAAAA_AAAA}; ws = '{4'hF};
        wr_txn(4'h6, 32'h8, 8'd0, 2'b01, 3'd2, 1);
        wd = '{32'h1122_3344}; ws = '{4'b0101};
        wr_txn(4'h7, 32'h8, 8'd0, 2'b01, 3'd2, 1);
        chk("reg2_merge", CW'(regs_o[95:64]), CW'(32'hAA22_AA44));

        // Second contended pair: read wins this time.
        wd = '{32'h5555_0001}; ws = '{4'hF};
        aw_start(4'h3, 32'h14, 8'd0, 2'b01, 3'd2);
        ar_start(4'h4, 32'h4, 8'd0, 2'b01, 3'd2);
        hs_wait(1);
        chk("arb_second_grant_rd", CW'(rdy_snap), CW'(2'b01));
        bus.ar_valid = 1'b0;
        r_phase(4'h4, 32'h4, 8'd0, 2'b01, 3'd2, 1'b0, 1'b1);
        hs_wait(0);
        bus.aw_valid = 1'b0;
        wr_finish(4'h3, 32'h14, 8'd0, 2'b01, 3'd2, 1);

        // Preload regs 6/7, then INCR read len 3 running off the end.
        wd = '{32'h6666_6666, 32'h7777_7777}; ws = '{4'hF, 4'hF};
        wr_txn(4'h8, 32'h18, 8'd1, 2'b01, 3'd2, 2);
        rd_txn(4'h9, 32'h18, 8'd3, 2'b01, 3'd2, 1'b0);

        // WRAP burst: all beats discarded, SLVERR.
        wd = '{32'hFFFF_FFFF, 32'hEEEE_EEEE}; ws = '{4'hF, 4'hF};
        wr_txn(4'hA, 32'h0, 8'd1, 2'b10, 3'd2, 2);

        // Early w_last: len 3 burst ended after 2 beats.
        wd = '{32'h1234_0000, 32'h1234_0001}; ws = '{4'hF, 4'hF};
        wr_txn(4'hB, 32'h8, 8'd3, 2'b01, 3'd2, 2);

        // Overlong burst: extra beat past len swallowed.
        wd = '{32'hCAFE_0000, 32'hCAFE_0001, 32'hCAFE_0002}; ws = '{4'hF, 4'hF, 4'hF};
        wr_txn(4'hC, 32'h0, 8'd1, 2'b01, 3'd2, 3);

        // FIXED write burst hits the same register each beat.
        wd = '{32'h0000_00A1, 32'h0000_B200}; ws = '{4'h1, 4'h2};
        wr_txn(4'hD, 32'hC, 8'd1, 2'b00, 3'd2, 2);

        // Reset while RDATA is stalled.
        ar_start(4'h2, 32'h4, 8'd2, 2'b01, 3'd2);
        hs_wait(1);
        bus.ar_valid = 1'b0;
        @(negedge clk);
        chk("r_valid_before_rst", CW'(bus.r_valid), CW'(1));
        rst = 1'b1;
        #1;
        chk("async_rst_abort", CW'({bus.r_valid, regs_o}), CW'({1'b0, {NR{RV}}}));
        for (int k = 0; k < NR; k++) mdl[k] = RV;
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #1;
        rd_txn(4'h3, 32'h4, 8'd1, 2'b01, 3'd2, 1'b0);

        // Randomized traffic.
        for (int t = 0; t < 40; t++) begin
            a  = ($urandom_range(0, NR + 2) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 9) == 0) a = 32'h0000_1000 | (a & 32'hFF);
            l  = 8'($urandom_range(0, 4));
            bu = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
            sz = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 1)) : 3'd2;
            if ($urandom_range(0, 1) == 0) begin
                nb = int'(l) + 1;
                case ($urandom_range(0, 5))
                    0: nb = (l == 0) ? 1 : int'(l);
                    1: nb = int'(l) + 2;
                    default: ;
                endcase
                for (int i = 0; i < nb; i++) begin
                    wd.push_back($urandom);
                    ws.push_back(4'($urandom_range(0, 15)));
                end
                wr_txn(4'($urandom_range(0, 15)), a, l, bu, sz, nb);
            end else begin
                rd_txn(4'($urandom_range(0, 15)), a, l, bu, sz, 1'b1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
